// File: rtl/subtracao_serie.sv
// ---------------------------------------------------------------------------
// subtracao_serie
//   Bit-serial 9-bit two's-complement subtractor driven by a push button.
//   A press of butSUB (asynchronous to clk) is synchronised, edge-detected
//   and starts one subtraction resSUB = sub1 - sub2. The subtraction is
//   done as sub1 + ~sub2 + 1, one bit per clock, LSB first, over 9 cycles.
//
// Ports
//   clk      in   system clock, all state changes on its rising edge
//   rst_n    in   asynchronous active-low reset
//   sub1     in   [8:0] minuend, two's complement
//   sub2     in   [8:0] subtrahend, two's complement
//   butSUB   in   subtract button, asynchronous level input
//   resSUB   out  [8:0] registered difference, held between operations
//   ovf      out  registered signed-overflow flag of the last result
//   ocupado  out  high while an operation is in progress (CALC and FIM)
//   pronto   out  one-cycle pulse when resSUB/ovf are updated
//
// Timing: for a start event in cycle N, resSUB/ovf/pronto are valid in
// cycle N+10 (one capture edge, nine serial bits, the result registers are
// loaded on the edge that enters FIM).
// ---------------------------------------------------------------------------
module subtracao_serie #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] sub1,
  input  logic [8:0] sub2,
  input  logic       butSUB,
  output logic [8:0] resSUB,
  output logic       ovf,
  output logic       ocupado,
  output logic       pronto
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIM  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Button synchroniser, edge detector and post-reset arming
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;   // extra flop after the synchroniser
  logic [SYNC_STAGES:0]   r_fill;     // marks when r_sync holds real samples
  logic                   r_armed;    // button seen low since reset
  logic                   w_sync_last;
  logic                   w_start;

  assign w_sync_last = r_sync[SYNC_STAGES-1];

  // The chain is cleared to zero by reset, so a button already held high at
  // release would look like a rising edge. r_fill tracks when the chain has
  // been flushed with genuine samples; only a low level observed after that
  // arms the detector, so the first accepted start needs a fresh press.
  assign w_start = w_sync_last & ~r_sync_d & r_armed;

  generate
    if (SYNC_STAGES > 1) begin : g_sync_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], butSUB};
        end
      end
    end else begin : g_sync_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= '0;
        end else begin
          r_sync <= butSUB;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_d <= 1'b0;
      r_fill   <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_sync_d <= w_sync_last;
      r_fill   <= {r_fill[SYNC_STAGES-1:0], 1'b1};
      if (r_fill[SYNC_STAGES] && !w_sync_last) begin
        r_armed <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Serial datapath
  // -------------------------------------------------------------------------
  state_t     r_state;
  logic [8:0] r_a;
  logic [8:0] r_b;          // holds ~sub2; the +1 comes from the initial carry
  logic       r_carry;
  logic [3:0] r_cnt;
  logic [8:0] r_shift;
  logic       r_sign_a;     // sign of the captured minuend
  logic       r_sign_b;     // sign of the captured subtrahend
  logic [8:0] r_res;
  logic       r_ovf;
  logic       r_ocupado;
  logic       r_pronto;

  logic       w_bit;
  logic       w_carry;
  logic [8:0] w_shift_next;
  logic       w_ovf;

  assign w_bit        = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry      = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_shift_next = {w_bit, r_shift[8:1]};

  // Signed overflow of a - b: operands of different sign and a result whose
  // sign differs from the minuend. Uses the signs captured at start.
  assign w_ovf = (r_sign_a != r_sign_b) && (w_shift_next[8] != r_sign_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_res     <= '0;
      r_ovf     <= 1'b0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pronto <= 1'b0;
          if (w_start) begin
            r_a       <= sub1;
            r_b       <= ~sub2;
            r_sign_a  <= sub1[8];
            r_sign_b  <= sub2[8];
            r_carry   <= 1'b1;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_ocupado <= 1'b1;
            r_state   <= CALC;
          end
        end

        CALC: begin
          r_shift <= w_shift_next;
          r_a     <= {1'b0, r_a[8:1]};
          r_b     <= {1'b0, r_b[8:1]};
          r_carry <= w_carry;
          r_cnt   <= r_cnt + 4'd1;
          // The last bit is folded straight into the output registers so
          // that they are already valid during the FIM cycle. The final
          // carry out is simply dropped.
          if (r_cnt == 4'd8) begin
            r_res    <= w_shift_next;
            r_ovf    <= w_ovf;
            r_pronto <= 1'b1;
            r_state  <= FIM;
          end
        end

        FIM: begin
          r_pronto  <= 1'b0;
          r_ocupado <= 1'b0;
          r_state   <= IDLE;
        end

        default: begin
          r_pronto  <= 1'b0;
          r_ocupado <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign resSUB  = r_res;
  assign ovf     = r_ovf;
  assign ocupado = r_ocupado;
  assign pronto  = r_pronto;

endmodule

// File: tb/tb_subtracao_serie.sv
// ---------------------------------------------------------------------------
// tb_subtracao_serie
//   Scoreboard bench for subtracao_serie. Stimulus pushes the expected
//   result, overflow and the cycle in which pronto must pulse; a monitor on
//   the falling edge pops and compares on every pronto.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_subtracao_serie;

  logic       clk;
  logic       rst_n;
  logic [8:0] sub1;
  logic [8:0] sub2;
  logic       butSUB;
  logic [8:0] resSUB;
  logic       ovf;
  logic       ocupado;
  logic       pronto;

  subtracao_serie #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sub1    (sub1),
    .sub2    (sub2),
    .butSUB  (butSUB),
    .resSUB  (resSUB),
    .ovf     (ovf),
    .ocupado (ocupado),
    .pronto  (pronto)
  );

  typedef struct {
    logic [8:0] res;
    logic       ovf;
    int         cyc;
    int         id;
  } exp_t;

  exp_t q[$];
  int   cyc       = 0;
  int   n_cmp     = 0;
  int   n_err     = 0;
  int   op_id     = 0;
  int   occ_cnt   = 0;
  bit   occ_en    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pronto must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (occ_en && ocupado) occ_cnt = occ_cnt + 1;
    if (pronto) begin
      if (q.size() == 0) begin
        n_cmp = n_cmp + 1;
        n_err = n_err + 1;
        $display("FAIL unexpected_pronto cyc=%0d res=%03h ovf=%0b required no pulse", cyc, resSUB, ovf);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_cmp = n_cmp + 1;
        if (resSUB !== e.res) begin
          n_err = n_err + 1;
          $display("FAIL op%0d_res got=%03h required=%03h", e.id, resSUB, e.res);
        end
        n_cmp = n_cmp + 1;
        if (ovf !== e.ovf) begin
          n_err = n_err + 1;
          $display("FAIL op%0d_ovf got=%0b required=%0b", e.id, ovf, e.ovf);
        end
        n_cmp = n_cmp + 1;
        if (cyc != e.cyc) begin
          n_err = n_err + 1;
          $display("FAIL op%0d_latency pronto_cyc=%0d required=%0d", e.id, cyc, e.cyc);
        end
        $display("op%0d: res=%03h ovf=%0b at cyc %0d", e.id, resSUB, ovf, cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] req);
    n_cmp = n_cmp + 1;
    if (got !== req) begin
      n_err = n_err + 1;
      $display("FAIL %s got=%03h required=%03h", name, got, req);
    end else begin
      $display("check %s = %03h ok", name, got);
    end
  endtask

  // Raise the button with new operands; optionally push the expectation.
  task automatic press(input logic [8:0] a, input logic [8:0] b, input bit expect_op,
                       input logic [8:0] er, input logic eo);
    exp_t e;
    sub1   = a;
    sub2   = b;
    butSUB = 1'b1;
    if (expect_op) begin
      op_id  = op_id + 1;
      e.res  = er;
      e.ovf  = eo;
      e.cyc  = cyc + 12;   // 2 sync edges to the start cycle, then +10
      e.id   = op_id;
      q.push_back(e);
    end
  endtask

  task automatic run_op(input logic [8:0] a, input logic [8:0] b,
                        input logic [8:0] er, input logic eo);
    press(a, b, 1'b1, er, eo);
    tick(3);
    butSUB = 1'b0;
    tick(12);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    butSUB = 1'b0;
    sub1   = '0;
    sub2   = '0;
    #23;
    check("reset_res", resSUB, 9'h000);
    check("reset_ovf", {8'd0, ovf}, 9'd0);
    check("reset_pronto", {8'd0, pronto}, 9'd0);
    check("reset_ocupado", {8'd0, ocupado}, 9'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(6);

    // Basic vectors
    run_op(9'h005, 9'h003, 9'h002, 1'b0);
    run_op(9'h003, 9'h005, 9'h1FE, 1'b0);
    run_op(9'h100, 9'h001, 9'h0FF, 1'b1);
    run_op(9'h0FF, 9'h1FF, 9'h100, 1'b1);
    run_op(9'h180, 9'h1C0, 9'h1C0, 1'b0);

    // Held button, toggle during CALC, operands changed mid-CALC
    occ_cnt = 0;
    occ_en  = 1'b1;
    press(9'h00A, 9'h004, 1'b1, 9'h006, 1'b0);
    tick(5);
    butSUB = 1'b0;
    sub1   = 9'h0F0;
    tick(1);
    butSUB = 1'b1;
    sub2   = 9'h1AA;
    tick(24);
    butSUB = 1'b0;
    tick(5);
    occ_en = 1'b0;
    check("held_ocupado_cycles", occ_cnt[8:0], 9'd10);

    // Reset during CALC cycle 4
    run_op(9'h005, 9'h003, 9'h002, 1'b0);
    press(9'h050, 9'h010, 1'b0, 9'h000, 1'b0);
    tick(3);
    butSUB = 1'b0;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_res", resSUB, 9'h000);
    check("abort_ocupado", {8'd0, ocupado}, 9'd0);
    check("abort_pronto", {8'd0, pronto}, 9'd0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    run_op(9'h050, 9'h010, 9'h040, 1'b0);

    // Button already high at reset release must not start anything
    butSUB = 1'b1;
    tick(1);
    rst_n = 1'b0;
    tick(2);
    rst_n   = 1'b1;
    occ_cnt = 0;
    occ_en  = 1'b1;
    tick(20);
    occ_en = 1'b0;
    check("held_at_release_ocupado_cycles", occ_cnt[8:0], 9'd0);
    butSUB = 1'b0;
    tick(6);
    run_op(9'h007, 9'h1FF, 9'h008, 1'b0);

    // Back-to-back: second start lands in the first IDLE cycle after FIM
    press(9'h07F, 9'h181, 1'b1, 9'h0FE, 1'b0);
    tick(3);
    butSUB = 1'b0;
    tick(8);
    press(9'h001, 9'h002, 1'b1, 9'h1FF, 1'b0);
    tick(3);
    butSUB = 1'b0;
    tick(14);

    check("hold_res_after_ops", resSUB, 9'h1FF);
    check("pronto_idle", {8'd0, pronto}, 9'd0);

    tick(5);
    n_cmp = n_cmp + 1;
    if (q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL missing_pronto outstanding=%0d required=0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
